// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state encoding and default sizing for the down counter.
package down_counter_pkg;
  localparam int DEFAULT_WIDTH = 7;
  localparam int PSC_W = 8;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/down_counter_ctrl_if.sv
// down_counter_ctrl_if: control and status bundle of the down counter.
interface down_counter_ctrl_if import down_counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;
  modport master (
    output start, pause, abort, auto_reload, load_val,
    input  count, busy, done, state
  );
  modport slave (
    input  start, pause, abort, auto_reload, load_val,
    output count, busy, done, state
  );
endinterface

// File: rtl/cnt_core.sv
// cnt_core: loadable down counter that saturates at zero.
module cnt_core #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_dec_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec_en && r_count != '0) r_count <= r_count - WIDTH'(1);
  assign o_count = r_count;
endmodule

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: start/pause/abort FSM with prescaled countdown and auto-reload.
module down_counter_ctrl import down_counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  down_counter_ctrl_if.slave  bus
);
  state_t           r_state, w_next;
  logic [PSC_W-1:0] r_presc, w_presc_nxt;
  logic [WIDTH-1:0] w_count, w_load_val;
  logic             w_tick, w_ld_nz, w_load, w_dec, w_run;
  assign w_tick     = r_presc == PSC_W'(DIV - 1);
  assign w_ld_nz    = |bus.load_val;
  assign w_run      = r_state == S_RUN && !bus.pause;
  // abort reuses the load path to clear the count
  assign w_load     = bus.abort || (r_state == S_IDLE && bus.start) ||
                      (r_state == S_DONE && bus.auto_reload && w_ld_nz);
  assign w_load_val = bus.abort ? '0 : bus.load_val;
  assign w_dec      = w_run && w_tick && !bus.abort;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = bus.abort ? S_IDLE :
             r_state == S_IDLE   ? (bus.start ? (w_ld_nz ? S_RUN : S_DONE) : S_IDLE) :
             r_state == S_RUN    ? (bus.pause ? S_PAUSED :
                                    (w_tick && w_count == WIDTH'(1)) ? S_DONE : S_RUN) :
             r_state == S_PAUSED ? (bus.pause ? S_PAUSED : S_RUN) :
             (bus.auto_reload && w_ld_nz) ? S_RUN : S_IDLE;
  end
  // a paused run keeps its prescaler phase
  assign w_presc_nxt = w_load ? '0 : w_run ? (w_tick ? '0 : r_presc + PSC_W'(1)) : r_presc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_presc <= '0;
    else r_presc <= w_presc_nxt;
  always_comb begin
    bus.busy  = r_state == S_RUN || r_state == S_PAUSED;
    bus.done  = r_state == S_DONE;
    bus.state = r_state;
    bus.count = w_count;
  end
  cnt_core #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_dec_en   (w_dec),
    .i_load_val (w_load_val),
    .o_count    (w_count)
  );
endmodule

// File: tb/tb_down_counter_ctrl.sv
// tb_down_counter_ctrl: directed checks of the down counter with DIV=1 and DIV=3 instances.
module tb_down_counter_ctrl;
  logic clk = 1'b1;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  down_counter_ctrl_if #(.WIDTH(7)) b1 ();
  down_counter_ctrl_if #(.WIDTH(7)) b3 ();
  down_counter_ctrl #(.WIDTH(7), .DIV(1)) d1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  down_counter_ctrl #(.WIDTH(7), .DIV(3)) d3 (.clk(clk), .reset_n(reset_n), .bus(b3));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {b1.start, b1.pause, b1.abort, b1.auto_reload} = '0;
    {b3.start, b3.pause, b3.abort, b3.auto_reload} = '0;
    b1.load_val = '0;
    b3.load_val = '0;
    #12;
    chk("rst_count", b1.count, 0);
    chk("rst_state", b1.state, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    #3 reset_n = 1'b1;
    b1.start = 1; b1.load_val = 5;
    step();
    b1.start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("div1_count", b1.count, 5 - i);
      chk("div1_busy", b1.busy, 1);
      chk("div1_done", b1.done, 0);
      step();
    end
    chk("div1_end_count", b1.count, 0);
    chk("div1_end_state", b1.state, 3);
    chk("div1_end_done", b1.done, 1);
    step();
    chk("div1_idle_state", b1.state, 0);
    chk("div1_idle_done", b1.done, 0);
    b3.start = 1; b3.load_val = 2;
    step();
    b3.start = 0;
    chk("div3_load", b3.count, 2);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("div3_count", b3.count, j < 3 ? 2 : 1);
      chk("div3_done", b3.done, 0);
    end
    step();
    chk("div3_end_count", b3.count, 0);
    chk("div3_end_done", b3.done, 1);
    step();
    chk("div3_idle", b3.state, 0);
    b1.start = 1; b1.load_val = 10;
    step();
    b1.start = 0;
    step(); step(); step();
    chk("pre_pause", b1.count, 7);
    b1.pause = 1;
    for (int k = 0; k < 4; k++) begin
      b1.start = k[0]; b1.load_val = 50;
      step();
      chk("pause_count", b1.count, 7);
      chk("pause_state", b1.state, 2);
      chk("pause_busy", b1.busy, 1);
    end
    b1.pause = 0; b1.start = 0;
    step();
    chk("resume_state", b1.state, 1);
    chk("resume_hold", b1.count, 7);
    step();
    chk("resume_count", b1.count, 6);
    step(); step();
    chk("pre_abort", b1.count, 4);
    b1.abort = 1; b1.start = 1; b1.load_val = 9;
    step();
    chk("abort_count", b1.count, 0);
    chk("abort_state", b1.state, 0);
    chk("abort_done", b1.done, 0);
    b1.abort = 0; b1.start = 0;
    step();
    chk("post_abort_state", b1.state, 0);
    chk("post_abort_count", b1.count, 0);
    b1.auto_reload = 1; b1.start = 1; b1.load_val = 3;
    step();
    b1.start = 0;
    chk("ar_load", b1.count, 3);
    for (int m = 0; m < 8; m++) begin
      step();
      chk("ar_count", b1.count, (m % 4 == 3) ? 3 : 2 - (m % 4));
      chk("ar_done", b1.done, (m % 4 == 2) ? 1 : 0);
      chk("ar_not_idle", b1.state == 0, 0);
    end
    b1.auto_reload = 0;
    step(); step(); step();
    chk("ar_off_done", b1.done, 1);
    step();
    chk("ar_off_idle", b1.state, 0);
    b1.start = 1; b1.load_val = 0;
    step();
    b1.start = 0;
    chk("zero_state", b1.state, 3);
    chk("zero_done", b1.done, 1);
    chk("zero_busy", b1.busy, 0);
    step();
    chk("zero_idle", b1.state, 0);
    chk("zero_idle_done", b1.done, 0);
    b1.start = 1; b1.load_val = 20;
    step();
    b1.start = 0;
    step(); step();
    chk("pre_reset", b1.count, 18);
    #2 reset_n = 0;
    #1;
    chk("async_rst_count", b1.count, 0);
    chk("async_rst_state", b1.state, 0);
    chk("async_rst_busy", b1.busy, 0);
    #3 reset_n = 1;
    step();
    chk("post_rst_state", b1.state, 0);
    chk("post_rst_done", b1.done, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/down_counter_ctrl.md
DOWN_COUNTER_CTRL -- requirements
Module: down_counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 7, counter width in bits.
REQ-002 Parameter DIV, default 1, clock cycles per count decrement; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level; sampled each edge; loads load_val and begins countdown when idle.
REQ-006 pause  input  1  level; holds count and prescaler while high during a run.
REQ-007 abort  input  1  level; returns block to IDLE from any state.
REQ-008 auto_reload  input  1  level; sampled in DONE; selects automatic restart.
REQ-009 load_val  input  WIDTH  start value for countdown.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 done  output  1  one-cycle pulse marking terminal count.
REQ-013 state  output  2  encoded FSM state: IDLE=0, RUN=1, PAUSED=2, DONE=3.

Function
REQ-014 FSM states shall be IDLE, RUN, PAUSED and DONE only; all outputs shall be registered or decoded from registered state.
REQ-015 Input priority shall be abort > start (IDLE only) > pause > prescaler tick.
REQ-016 abort=1 at any edge: next state IDLE, count=0, prescaler=0, done=0.
REQ-017 IDLE, start=1, load_val!=0: count=load_val, prescaler=0, next state RUN.
REQ-018 IDLE, start=1, load_val=0: count=0, next state DONE (done pulse, no RUN cycles).
REQ-019 IDLE, start=0: count holds its value.
REQ-020 RUN: prescaler increments each edge; tick is the edge at which prescaler=DIV-1, and prescaler then returns to 0.
REQ-021 RUN, tick, count>1: count decrements by 1.
REQ-022 RUN, tick, count=1: count=0, next state DONE; count shall never wrap below 0.
REQ-023 Latency for DIV=1: start sampled at edge k with load_val=N; count=0 and state=DONE after edge k+N.
REQ-024 done shall equal (state==DONE), high for exactly one cycle per terminal count.
REQ-025 RUN, pause=1: next state PAUSED; the tick at the same edge is suppressed.
REQ-026 PAUSED: count and prescaler hold; pause=0 gives next state RUN, resuming with the held prescaler value.
REQ-027 start in RUN, PAUSED or DONE shall be ignored.
REQ-028 DONE, auto_reload=1, load_val!=0: count=load_val, prescaler=0, next state RUN.
REQ-029 DONE, otherwise: count holds 0, next state IDLE.

Reset
REQ-030 reset_n=0 shall immediately force state=IDLE, count=0, prescaler=0, busy=0, done=0, independent of clk.
REQ-031 Release of reset_n shall take effect at the first rising clk edge after deassertion; reset asserted mid-run shall abandon the run with no done pulse.

Structure
REQ-032 A shared package down_counter_pkg shall hold the state encoding constants and the default WIDTH.
REQ-033 The counter datapath shall be a sub-module cnt_core: load, dec_en and load_val inputs, count output, async active-low reset, saturating at 0.
REQ-034 down_counter_ctrl shall contain the FSM, the prescaler and the output decode only.

Verification
REQ-035 reset_n=0 for 15 ns, then start=1 with load_val=5 and DIV=1 -> count 5,4,3,2,1,0 on consecutive edges; done high exactly one cycle; then IDLE.
REQ-036 DIV=3, load_val=2 -> count decrements every 3rd edge; done pulse 6 cycles after the load edge.
REQ-037 load_val=10, pause=1 for 4 cycles while count=7 -> count stays 7 and state=PAUSED; count resumes at 6 after pause drops.
REQ-038 auto_reload=1, load_val=3 -> repeating sequence 3,2,1,0,3,2,1,0 with one done pulse per period and no IDLE cycle.
REQ-039 abort=1 while count=4 in RUN -> count=0, state IDLE next edge, no done; start=1 in the same cycle has no effect.
REQ-040 start=1 with load_val=0 -> DONE for one cycle, done=1, then IDLE; reset_n=0 mid-run -> asynchronous return to IDLE with count=0.
